// File: rtl/hmmm_mem_responder.sv
// Word memory for the 8-bit HMMM core, with a byte-stream loader that fills it while the core is held in reset.
// Optional `define MEM_WRITE_PROTECT_EN: core writes below WP_LIMIT are dropped and flagged on wp_err.
module hmmm_mem_responder #(
  parameter int            AW       = 8,
  parameter int            DW       = 15,
  parameter logic [AW-1:0] WP_LIMIT = '0
) (
  input  logic          ph1,
  input  logic          reset,
  input  logic          MemWrite,
  input  logic [AW-1:0] Adr,
  inout  wire  [DW-1:0] MemData,
  output logic          cpu_reset,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [7:0]    ld_data,
  output logic          ld_err,
  output logic [AW:0]   words_loaded,
  output logic          wp_err
);

  localparam logic [7:0] CMD_LOAD = 8'hA5;
  localparam logic [7:0] CMD_RUN  = 8'h5A;
  localparam logic [7:0] CMD_HALT = 8'hC3;

  typedef enum logic [2:0] {IDLE, ADDR, HI, LO, WR} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_word;
  logic          xfer;
  logic          set_run, set_halt, set_err;
  logic          protect_on, below_limit, core_we;
  logic [AW-1:0] wp_limit;

  assign xfer     = ld_valid & ld_ready;
  assign ld_ready = (state != WR);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    set_run  = 1'b0;
    set_halt = 1'b0;
    set_err  = 1'b0;
    case (state)
      IDLE: if (xfer) begin
        case (ld_data)
          CMD_LOAD: if (cpu_reset) state_nx = ADDR; else set_err = 1'b1;
          CMD_RUN:  set_run  = 1'b1;
          CMD_HALT: set_halt = 1'b1;
          default:  set_err  = 1'b1;
        endcase
      end
      ADDR:    if (xfer) state_nx = HI;
      HI:      if (xfer) state_nx = LO;
      LO:      if (xfer) state_nx = WR;
      WR:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge ph1) begin
    if (reset) begin
      state        <= IDLE;
      cpu_reset    <= 1'b1;
      ld_err       <= 1'b0;
      words_loaded <= '0;
    end else begin
      state <= state_nx;
      if (set_run)       cpu_reset <= 1'b0;
      else if (set_halt) cpu_reset <= 1'b1;
      if (set_err) ld_err <= 1'b1;
      if (state == WR && !words_loaded[AW])
        words_loaded <= words_loaded + (AW+1)'(1);
    end
  end

  // Frame assembly registers; a frame cut short by reset is simply never committed.
  always_ff @(posedge ph1) begin
    if (xfer && state == ADDR) ld_addr           <= AW'(ld_data);
    if (xfer && state == HI)   ld_word[DW-1:8]   <= ld_data[DW-9:0];
    if (xfer && state == LO)   ld_word[7:0]      <= ld_data;
  end

  assign wp_limit    = WP_LIMIT;
  assign below_limit = (Adr < wp_limit);

`ifdef MEM_WRITE_PROTECT_EN
  assign protect_on = 1'b1;

  always_ff @(posedge ph1) begin
    if (reset)
      wp_err <= 1'b0;
    else if (!cpu_reset && MemWrite && below_limit)
      wp_err <= 1'b1;
  end
`else
  assign protect_on = 1'b0;
  assign wp_err     = 1'b0;
`endif

  assign core_we = !cpu_reset && MemWrite && !(protect_on && below_limit);

  // NOTE: the array has no reset; contents survive reset and only the control state is cleared.
  always_ff @(posedge ph1) begin
    if (!reset) begin
      if (state == WR)
        mem[ld_addr] <= ld_word;
      else if (core_we)
        mem[Adr] <= {{(DW-8){1'b0}}, MemData[7:0]};
    end
  end

  // The core only sees the array while it runs and is not itself driving the bus.
  assign MemData = (!cpu_reset && !MemWrite) ? mem[Adr] : {DW{1'bz}};

endmodule
